// File: rtl/ga_pkg.sv
// Shared constants, state encoding and helpers for the GA selection stage.
package ga_pkg;

  localparam int NUM_IND = 50;
  localparam int IND_W   = 150;
  localparam int FIT_W   = 8;
  localparam int IDX_W   = 6;

  localparam logic [15:0] LFSR_TAPS = 16'hB400;
  localparam logic [15:0] LFSR_SEED = 16'hACE1;

  typedef enum logic [1:0] {
    IDLE,
    EVAL,
    SELECT,
    DONE
  } state_t;

  function automatic logic [15:0] lfsr_step(
    input logic [15:0] v
  );
    return v[0] ? ((v >> 1) ^ LFSR_TAPS)
                : (v >> 1);
  endfunction

  // Raw LFSR fields span 0..63; fold them into 0..NUM_IND-1.
  function automatic logic [IDX_W-1:0] idx_wrap(
    input logic [IDX_W-1:0] v
  );
    return (v >= IDX_W'(NUM_IND))
      ? v - IDX_W'(NUM_IND)
      : v;
  endfunction

endpackage

// File: rtl/ga_fitness.sv
// Combinational fitness: population count of one individual.
module ga_fitness
  import ga_pkg::*;
(
  input  logic [IND_W-1:0] ind,
  output logic [FIT_W-1:0] fit
);

  always_comb begin
    fit = '0;
    for (int i = 0; i < IND_W; i++) begin
      fit = fit + FIT_W'(ind[i]);
    end
  end

endmodule

// File: rtl/ga_tournament_select.sv
// Selection stage: scores the population, keeps the elite in slot 0
// and fills the other slots with binary-tournament winners.
module ga_tournament_select
  import ga_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_IND*IND_W-1:0] population,
  input  logic                     sel_start,
  output logic [NUM_IND*IND_W-1:0] sel_pop,
  output logic                     sel_done
);

  localparam logic [IDX_W-1:0] LAST =
    IDX_W'(NUM_IND - 1);

  state_t state, nxt;

  logic [IND_W-1:0] pop_reg [NUM_IND];
  logic [IND_W-1:0] sel_arr [NUM_IND];
  logic [FIT_W-1:0] fit     [NUM_IND];

  logic [FIT_W-1:0] best_fit;
  logic [FIT_W-1:0] cur_fit;
  logic [IDX_W-1:0] best_idx;
  logic [IDX_W-1:0] idx;
  logic [IDX_W-1:0] slot;
  logic [IDX_W-1:0] a;
  logic [IDX_W-1:0] b;
  logic [IDX_W-1:0] winner;
  logic [15:0]      lfsr;

  ga_fitness u_fit (
    .ind (pop_reg[idx]),
    .fit (cur_fit)
  );

  always_comb begin
    a      = idx_wrap(lfsr[IDX_W-1:0]);
    b      = idx_wrap(lfsr[IDX_W+7:8]);
    winner = (fit[b] > fit[a]) ? b : a;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= nxt;
  end

  always_comb begin
    nxt = state;
    unique case (state)
      IDLE: begin
        if (sel_start) nxt = EVAL;
      end
      EVAL: begin
        if (!sel_start)       nxt = IDLE;
        else if (idx == LAST) nxt = SELECT;
      end
      SELECT: begin
        if (!sel_start)        nxt = IDLE;
        else if (slot == LAST) nxt = DONE;
      end
      DONE: begin
        if (!sel_start) nxt = IDLE;
      end
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_IND; i++) begin
        pop_reg[i] <= '0;
        sel_arr[i] <= '0;
        fit[i]     <= '0;
      end
      best_fit <= '0;
      best_idx <= '0;
      idx      <= '0;
      slot     <= '0;
      lfsr     <= LFSR_SEED;
    end else begin
      unique case (state)
        IDLE: begin
          if (sel_start) begin
            for (int i = 0; i < NUM_IND; i++) begin
              pop_reg[i] <= population[i*IND_W +: IND_W];
              fit[i]     <= '0;
            end
            best_fit <= '0;
            best_idx <= '0;
            idx      <= '0;
            slot     <= '0;
          end
        end
        EVAL: begin
          if (sel_start) begin
            fit[idx] <= cur_fit;
            // Strict compare: ties keep the lower index.
            if (cur_fit > best_fit) begin
              best_fit <= cur_fit;
              best_idx <= idx;
            end
            if (idx != LAST) idx <= idx + IDX_W'(1);
          end
        end
        SELECT: begin
          if (sel_start) begin
            sel_arr[slot] <= (slot == '0)
              ? pop_reg[best_idx]
              : pop_reg[winner];
            if (slot != LAST) slot <= slot + IDX_W'(1);
            lfsr <= lfsr_step(lfsr);
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    for (int i = 0; i < NUM_IND; i++) begin
      sel_pop[i*IND_W +: IND_W] = sel_arr[i];
    end
  end

  assign sel_done = (state == DONE);

endmodule

// File: tb/tb_ga_tournament_select.sv
// Scoreboard bench for ga_tournament_select with a behavioural
// reference of elite + binary tournament selection.
module tb_ga_tournament_select;

  localparam int N  = 50;
  localparam int W  = 150;
  localparam int LAT = 100;

  typedef struct {
    logic [N*W-1:0] pop;
    int             done_cyc;
  } exp_t;

  logic           clk;
  logic           rst;
  logic [N*W-1:0] population;
  logic           sel_start;
  logic [N*W-1:0] sel_pop;
  logic           sel_done;

  logic [W-1:0] pop_m   [N];
  logic [W-1:0] exp_pop [N];
  logic [15:0]  m_lfsr;
  int           m_best;
  int           cyc;
  int           checks;
  int           errors;
  logic         done_q;
  exp_t         sb_q [$];

  ga_tournament_select dut (
    .clk        (clk),
    .rst        (rst),
    .population (population),
    .sel_start  (sel_start),
    .sel_pop    (sel_pop),
    .sel_done   (sel_done)
  );

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  always_comb begin
    for (int i = 0; i < N; i++) population[i*W +: W] = pop_m[i];
  end

  task automatic chk(string nm, logic [W-1:0] act, logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  // Reference: fitness = ones count, elite = first maximum,
  // tournaments driven by the 16-bit Galois sequence.
  task automatic model(input int nslots);
    int f [N];
    int bf, a, b;
    bf = 0;
    m_best = 0;
    for (int i = 0; i < N; i++) begin
      f[i] = $countones(pop_m[i]);
      if (f[i] > bf) begin
        bf = f[i];
        m_best = i;
      end
    end
    for (int s = 0; s < nslots; s++) begin
      if (s == 0) begin
        exp_pop[0] = pop_m[m_best];
      end else begin
        a = int'(m_lfsr) % 64;
        b = (int'(m_lfsr) / 256) % 64;
        if (a >= N) a -= N;
        if (b >= N) b -= N;
        exp_pop[s] = (f[b] > f[a]) ? pop_m[b] : pop_m[a];
      end
      m_lfsr = (m_lfsr >> 1) ^ (m_lfsr[0] ? 16'hB400 : 16'h0000);
    end
  endtask

  task automatic do_reset();
    rst = 1;
    sel_start = 0;
    @(negedge clk);
    rst = 0;
    m_lfsr = 16'hACE1;
    for (int i = 0; i < N; i++) exp_pop[i] = '0;
    sb_q.delete();
  endtask

  task automatic fill_random(input int mode);
    logic [159:0] t;
    for (int i = 0; i < N; i++) begin
      for (int k = 0; k < 5; k++) begin
        t[k*32 +: 32] = $urandom;
        if (mode == 1) t[k*32 +: 32] &= $urandom;
        if (mode == 2) t[k*32 +: 32] |= $urandom;
      end
      pop_m[i] = t[W-1:0];
    end
  endtask

  task automatic run(input int hold);
    exp_t e;
    int   n;
    @(negedge clk);
    sel_start = 1;
    model(N);
    for (int i = 0; i < N; i++) e.pop[i*W +: W] = exp_pop[i];
    e.done_cyc = cyc + 1 + LAT;
    sb_q.push_back(e);
    n = 0;
    while (!sel_done && n < 2 * LAT) begin
      @(negedge clk);
      n++;
    end
    if (!sel_done) begin
      errors++;
      checks++;
      $display("FAIL done_timeout actual=0 expected=1");
      sb_q.delete();
    end
    repeat (hold) begin
      @(negedge clk);
      chk("done_hold", W'(sel_done), W'(1));
    end
    sel_start = 0;
    @(negedge clk);
    chk("done_fall", W'(sel_done), W'(0));
    chk("lfsr_after", W'(dut.lfsr), W'(m_lfsr));
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (sel_done && !done_q) begin
      if (sb_q.size() == 0) begin
        errors++;
        checks++;
        $display("FAIL unexpected_done actual=1 expected=0");
      end else begin
        e = sb_q.pop_front();
        chk("latency", W'(cyc), W'(e.done_cyc));
        for (int s = 0; s < N; s++)
          chk($sformatf("slot%0d", s),
              sel_pop[s*W +: W], e.pop[s*W +: W]);
      end
    end
    done_q = sel_done;
  end

  initial begin
    logic [151:0] pat;
    logic [W-1:0] ones;
    int c;
    checks = 0;
    errors = 0;
    done_q = 0;
    cyc = 0;
    ones = '1;
    for (int i = 0; i < N; i++) pop_m[i] = '0;
    rst = 0;
    sel_start = 0;
    #2 rst = 1;
    #1;
    chk("rst_done", W'(sel_done), W'(0));
    chk("rst_lfsr", W'(dut.lfsr), W'(16'hACE1));
    @(negedge clk);
    do_reset();
    chk("rst_pop", W'($countones(sel_pop)), W'(0));

    pop_m[7] = ones;
    run(0);
    chk("elite_slot0", sel_pop[0 +: W], ones);
    chk("elite_idx", W'(dut.best_idx), W'(7));

    pat = {19{8'h5A}};
    for (int i = 0; i < N; i++) pop_m[i] = pat[W-1:0];
    run(20);
    chk("uniform_best", W'(dut.best_idx), W'(0));

    for (int i = 0; i < N; i++) pop_m[i] = '0;
    pop_m[3] = ones;
    pop_m[9] = ones;
    run(3);
    chk("tie_best", W'(dut.best_idx), W'(3));

    for (int r = 0; r < 3; r++) begin
      fill_random(r);
      run(1);
    end

    fill_random(0);
    @(negedge clk);
    sel_start = 1;
    c = cyc;
    while (cyc < c + 26) @(negedge clk);
    #2;
    rst = 1;
    sel_start = 0;
    #1;
    chk("midrst_done", W'(sel_done), W'(0));
    chk("midrst_pop", W'($countones(sel_pop)), W'(0));
    chk("midrst_lfsr", W'(dut.lfsr), W'(16'hACE1));
    @(negedge clk);
    do_reset();
    run(0);

    fill_random(1);
    @(negedge clk);
    sel_start = 1;
    c = cyc;
    model(10);
    while (cyc < c + 61) @(negedge clk);
    sel_start = 0;
    @(negedge clk);
    chk("abort_done", W'(sel_done), W'(0));
    for (int s = 0; s < N; s++)
      chk($sformatf("abort_slot%0d", s), sel_pop[s*W +: W], exp_pop[s]);
    repeat (5) begin
      @(negedge clk);
      chk("abort_idle", W'(sel_done), W'(0));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
